// File: rtl/psg_envelope_generator_if.sv
// Envelope generator bus: period/shape/restart from the register block,
// shared envelope level and status back to the mixer.
interface psg_envelope_generator_if #(
  parameter int PERIOD_BITS = 16,
  parameter int STEP_BITS   = 4
);
  logic [PERIOD_BITS-1:0] period;
  logic [3:0]             shape;
  logic                   restart;
  logic [STEP_BITS-1:0]   envelope;
  logic                   holding;
  logic                   cycle_end;

  modport master (
    output period, shape, restart,
    input  envelope, holding, cycle_end
  );

  modport slave (
    input  period, shape, restart,
    output envelope, holding, cycle_end
  );
endinterface

// File: rtl/psg_envelope_generator.sv
// AY-3-891x / YM2149 compatible envelope generator: prescaled period timer
// driving a ramp step counter shaped by the R13 {continue, attack, alternate, hold} bits.
module psg_envelope_generator #(
  parameter int PERIOD_BITS  = 16,
  parameter int STEP_BITS    = 4,
  parameter int PRESCALE_DIV = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  psg_envelope_generator_if.slave  bus
);
  localparam int                   PS_W     = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0]      PS_LAST  = PS_W'(PRESCALE_DIV - 1);
  localparam logic [STEP_BITS-1:0] STEP_MAX = '1;

  logic [PS_W-1:0]        r_prescale;
  logic [PERIOD_BITS-1:0] r_period_cnt;
  logic [STEP_BITS-1:0]   r_step;
  logic [3:0]             r_shape_q;
  logic                   r_inv;
  logic                   r_holding;
  logic                   r_cycle_end;
  logic [STEP_BITS-1:0]   r_envelope;

  logic                   w_tick;
  logic                   w_advance;
  logic [PERIOD_BITS-1:0] w_period_m1;
  logic [PS_W-1:0]        w_prescale_nxt;
  logic [PERIOD_BITS-1:0] w_period_cnt_nxt;
  logic [STEP_BITS-1:0]   w_step_nxt;
  logic [3:0]             w_shape_nxt;
  logic                   w_inv_nxt;
  logic                   w_holding_nxt;
  logic                   w_cycle_end_nxt;
  logic [STEP_BITS-1:0]   w_envelope_nxt;

  // A period of 0 counts like 1, so the terminal count never underflows.
  assign w_period_m1 = (bus.period == '0) ? '0 : bus.period - PERIOD_BITS'(1);
  assign w_tick      = (r_prescale == PS_LAST);
  assign w_advance   = w_tick && (r_period_cnt >= w_period_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale   <= '0;
      r_period_cnt <= '0;
      r_step       <= '0;
      r_shape_q    <= '0;
      r_inv        <= 1'b0;
      r_holding    <= 1'b1;
      r_cycle_end  <= 1'b0;
      r_envelope   <= '0;
    end else begin
      r_prescale   <= w_prescale_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_step       <= w_step_nxt;
      r_shape_q    <= w_shape_nxt;
      r_inv        <= w_inv_nxt;
      r_holding    <= w_holding_nxt;
      r_cycle_end  <= w_cycle_end_nxt;
      r_envelope   <= w_envelope_nxt;
    end
  end

  // Restart wins over a coincident advance; timers keep running while holding.
  always_comb begin
    w_prescale_nxt   = w_tick ? '0 : r_prescale + PS_W'(1);
    w_period_cnt_nxt = r_period_cnt;
    w_step_nxt       = r_step;
    w_shape_nxt      = r_shape_q;
    w_inv_nxt        = r_inv;
    w_holding_nxt    = r_holding;
    w_cycle_end_nxt  = 1'b0;
    if (w_tick) begin
      w_period_cnt_nxt = w_advance ? '0 : r_period_cnt + PERIOD_BITS'(1);
    end
    if (bus.restart) begin
      w_prescale_nxt   = '0;
      w_period_cnt_nxt = '0;
      w_step_nxt       = '0;
      w_shape_nxt      = bus.shape;
      w_inv_nxt        = ~bus.shape[2];
      w_holding_nxt    = 1'b0;
    end else if (w_advance && !r_holding) begin
      if (r_step != STEP_MAX) begin
        w_step_nxt = r_step + STEP_BITS'(1);
      end else begin
        w_cycle_end_nxt = 1'b1;
        if (!r_shape_q[3]) begin
          w_holding_nxt = 1'b1;
        end else begin
          if (r_shape_q[1]) w_inv_nxt = ~r_inv;
          if (r_shape_q[0]) w_holding_nxt = 1'b1;
          else              w_step_nxt    = '0;
        end
      end
    end
  end

  // One-shot shapes (continue = 0) read 0 once frozen.
  always_comb begin
    w_envelope_nxt = w_inv_nxt ? (STEP_MAX - w_step_nxt) : w_step_nxt;
    if (w_holding_nxt && !w_shape_nxt[3]) w_envelope_nxt = '0;
  end

  assign bus.envelope  = r_envelope;
  assign bus.holding   = r_holding;
  assign bus.cycle_end = r_cycle_end;
endmodule

// File: tb/tb_psg_envelope_generator.sv
// Scoreboard bench for psg_envelope_generator: three instances cover the
// AY/prescaled, AY/unprescaled and YM 32-step configurations.
module tb_psg_envelope_generator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   q_exp[$];

  psg_envelope_generator_if #(.PERIOD_BITS(16), .STEP_BITS(4)) if_a ();
  psg_envelope_generator_if #(.PERIOD_BITS(16), .STEP_BITS(4)) if_b ();
  psg_envelope_generator_if #(.PERIOD_BITS(16), .STEP_BITS(5)) if_c ();

  psg_envelope_generator #(.PERIOD_BITS(16), .STEP_BITS(4), .PRESCALE_DIV(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  psg_envelope_generator #(.PERIOD_BITS(16), .STEP_BITS(4), .PRESCALE_DIV(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  psg_envelope_generator #(.PERIOD_BITS(16), .STEP_BITS(5), .PRESCALE_DIV(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packed view: envelope | holding<<8 | cycle_end<<9
  function automatic int pk(input int env, input int hold, input int ce);
    return env | (hold << 8) | (ce << 9);
  endfunction

  function automatic int obs(input int sel);
    case (sel)
      0:       return pk(int'(if_a.envelope), int'(if_a.holding), int'(if_a.cycle_end));
      1:       return pk(int'(if_b.envelope), int'(if_b.holding), int'(if_b.cycle_end));
      default: return pk(int'(if_c.envelope), int'(if_c.holding), int'(if_c.cycle_end));
    endcase
  endfunction

  task automatic drive(input int sel, input int per, input logic [3:0] shp, input logic rs);
    case (sel)
      0:       begin if_a.period = 16'(per); if_a.shape = shp; if_a.restart = rs; end
      1:       begin if_b.period = 16'(per); if_b.shape = shp; if_b.restart = rs; end
      default: begin if_c.period = 16'(per); if_c.shape = shp; if_c.restart = rs; end
    endcase
  endtask

  // Leaves the bench at the first negedge after the edge that took the restart.
  task automatic start(input int sel, input int per, input logic [3:0] shp);
    @(negedge clk);
    drive(sel, per, shp, 1'b1);
    @(negedge clk);
    drive(sel, per, shp, 1'b0);
  endtask

  task automatic run_sb(input int sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (q_exp.size() == 0) begin
        check_val({tag, "_sb_empty"}, 1, 0);
        return;
      end
      check_val($sformatf("%s_k%0d", tag, i), obs(sel), q_exp.pop_front());
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    for (int s = 0; s < 3; s++) drive(s, 1, 4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) check_val($sformatf("reset_%0d", s), obs(s), pk(0, 1, 0));
    @(negedge clk);
    rst_n = 1'b1;
    check_val("reset_release", obs(1), pk(0, 1, 0));

    // Attack + hold, prescale 4, period 2: one step every 8 clocks.
    start(0, 2, 4'b1101);
    for (int k = 0; k < 200; k++)
      q_exp.push_back(pk((k / 8 > 15) ? 15 : k / 8, int'(k >= 128), int'(k == 128)));
    run_sb(0, 200, "t2");

    // Restart coincident with the first advance (edge 8) must win.
    start(0, 2, 4'b1101);
    for (int k = 0; k < 7; k++) q_exp.push_back(pk(0, 0, 0));
    run_sb(0, 7, "t6a_pre");
    drive(0, 2, 4'b1101, 1'b1);
    q_exp.push_back(pk(0, 0, 0));
    run_sb(0, 1, "t6a_arm");
    drive(0, 2, 4'b1101, 1'b0);
    for (int k = 0; k < 21; k++) q_exp.push_back(pk(k / 8, 0, 0));
    run_sb(0, 21, "t6a_post");

    // Period 100 shortened to 5 with the counter at 50.
    start(0, 100, 4'b1101);
    for (int k = 0; k <= 200; k++) q_exp.push_back(pk(0, 0, 0));
    run_sb(0, 201, "t6b_pre");
    drive(0, 5, 4'b1101, 1'b0);
    for (int k = 201; k < 231; k++)
      q_exp.push_back(pk((k < 204) ? 0 : ((k < 224) ? 1 : 2), 0, 0));
    run_sb(0, 30, "t6b_post");

    // Triangle, no prescale.
    start(1, 1, 4'b1110);
    for (int k = 0; k < 64; k++) begin
      int s;
      s = k % 16;
      q_exp.push_back(pk(((k / 16) % 2 == 0) ? s : 15 - s, 0, int'(k > 0 && s == 0)));
    end
    run_sb(1, 64, "t3");

    // One-shot decay; period 0 must behave as period 1.
    for (int per = 0; per < 2; per++) begin
      start(1, per, 4'b0000);
      for (int k = 0; k < 40; k++)
        q_exp.push_back(pk((k < 16) ? 15 - k : 0, int'(k >= 16), int'(k == 16)));
      run_sb(1, 40, $sformatf("t4_p%0d", per));
    end

    // YM 32-step decaying saw.
    start(2, 1, 4'b1000);
    for (int k = 0; k < 100; k++)
      q_exp.push_back(pk(31 - (k % 32), 0, int'(k > 0 && k % 32 == 0)));
    run_sb(2, 100, "t5");

    // Reset mid-ramp, then silence without a restart.
    start(1, 3, 4'b1010);
    for (int k = 0; k < 10; k++) q_exp.push_back(pk(15 - k / 3, 0, 0));
    run_sb(1, 10, "t1_ramp");
    rst_n = 1'b0;
    #1;
    check_val("t1_async", obs(1), pk(0, 1, 0));
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (obs(1) != pk(0, 1, 0)) bad++;
    end
    check_val("t1_quiet", bad, 0);
    check_val("sb_drained", q_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
